c64_bus_arbiter: RTL and testbench
==================================

C64_BUS_ARBITER -- requirements
Module: c64_bus_arbiter

Interface
REQ-001 Parameter BA_LEAD, default 3, is the number of warning cycles between the video request being accepted and the video grant; legal range 1..7.
REQ-002 Parameter REFRESH_PERIOD, default 64, is the number of clock cycles between refresh requests; legal range 4..255.
REQ-003 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_ab  in  16  CPU address.
REQ-006 cpu_do  in  8  CPU write data.
REQ-007 cpu_we  in  1  CPU write enable.
REQ-008 cpu_rdy  out  1  CPU may advance; when low, the CPU holds its current cycle.
REQ-009 cpu_di  out  8  read data to the CPU; equals mem_di.
REQ-010 vid_req  in  1  video fetcher requests the bus; held high for the whole burst.
REQ-011 vid_ab  in  16  video fetch address.
REQ-012 vid_grant  out  1  video owns the memory bus this cycle.
REQ-013 vid_valid  out  1  vid_di carries data for the previous granted cycle.
REQ-014 vid_di  out  8  read data to video; equals mem_di.
REQ-015 mem_ab  out  16  memory address.
REQ-016 mem_do  out  8  memory write data; equals cpu_do.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_di  in  8  memory read data, valid one cycle after its address (synchronous RAM).

Function
REQ-019 The state machine has four states: CPU, LEAD, VIDEO and REFRESH.
REQ-020 Outputs are combinational decodes of the state:
- CPU: cpu_rdy=1, mem_ab=cpu_ab, mem_we=cpu_we.
- LEAD: cpu_rdy=0, mem_ab=cpu_ab, mem_we=cpu_we. Writes in progress complete, because the CPU cannot halt on a write.
- VIDEO: vid_grant=1, mem_ab=vid_ab, mem_we=0.
- REFRESH: mem_ab={8'hFF, ref_row}, mem_we=0.
- vid_grant=0 in every state except VIDEO; cpu_rdy=0 in every state except CPU.
REQ-021 From CPU, with vid_req=1, the next state is LEAD and lead_cnt loads BA_LEAD-1. vid_req has priority over a pending refresh.
REQ-022 In LEAD with vid_req=1:
- lead_cnt>0: lead_cnt decrements.
- lead_cnt=0: the next state is VIDEO.
- Result: vid_grant first rises exactly BA_LEAD+1 cycles after the edge on which vid_req was sampled in CPU.
REQ-023 In LEAD with vid_req=0, the request is aborted and the next state is CPU (or REFRESH per REQ-026); no grant is issued.
REQ-024 VIDEO persists while vid_req=1. With vid_req=0, the next state is REFRESH if ref_pending=1, otherwise CPU.
REQ-025 Refresh timer:
- ref_timer is an 8-bit counter incrementing every cycle.
- On reaching REFRESH_PERIOD-1 it wraps to 0 and sets ref_pending.
- If ref_pending is already set, it stays set; requests do not accumulate.
REQ-026 From CPU (or an aborting LEAD), with ref_pending=1, vid_req=0 and cpu_we=0, the next state is REFRESH. If cpu_we=1, the refresh is deferred.
REQ-027 REFRESH lasts exactly one cycle, then the next state is CPU. On exit, ref_pending clears and ref_row increments with 8-bit wrap-around (FF->00). If the timer sets ref_pending on that same edge, the set wins.
REQ-028 vid_valid is vid_grant registered by one cycle.

Reset
REQ-029 With reset high on a clock edge:
- state=CPU, lead_cnt=0, ref_timer=0, ref_pending=0, ref_row=0, vid_valid=0.
- Hence cpu_rdy=1 and vid_grant=0 in the following cycle.
REQ-030 Reset asserted in any state, including mid-burst in VIDEO or LEAD, returns the block to CPU on the next edge, with no further grant or refresh.

Verification
REQ-031 Video burst: vid_req=1 for 10 cycles starting in CPU with BA_LEAD=3. Required response:
- cpu_rdy low from cycle+1.
- vid_grant high cycles +4..+10 (after 3 LEAD cycles).
- mem_ab=vid_ab during grant.
- vid_valid delayed one cycle.
- cpu_rdy high again after vid_req falls.
REQ-032 Write during LEAD: cpu_we=1, cpu_ab=16'hD020, cpu_do=8'h05 in the first LEAD cycle. Required response: mem_we=1, mem_ab=16'hD020, mem_do=8'h05 in that cycle, and cpu_rdy=0.
REQ-033 Abort: vid_req high for 2 cycles only. Required response: vid_grant never rises, and cpu_rdy returns high 1 cycle after vid_req falls.
REQ-034 Refresh: idle CPU reads, REFRESH_PERIOD=64. Required response:
- One REFRESH cycle every 64 cycles, with mem_ab=16'hFF00, then 16'hFF01, ...
- ref_row wraps FF->00 after 256 refreshes.
- Refresh is deferred while cpu_we=1.
REQ-035 Collision: ref_pending rises during a video burst. Required response: REFRESH occurs in the cycle immediately after VIDEO ends, then CPU resumes.
REQ-036 Reset mid-VIDEO. Required response: vid_grant=0 and cpu_rdy=1 one cycle after the reset edge, and ref_row=0.

Source files
------------

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - CPU / video / DRAM-refresh memory bus arbiter
//
// Purpose: shares one synchronous-RAM port between the CPU, a video fetcher
// (with a BA-style warning lead before the CPU loses the bus) and a periodic
// DRAM refresh cycle.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cpu_ab/do/we        CPU address, write data, write enable
//   cpu_rdy, cpu_di     CPU may advance; read data (= mem_di)
//   vid_req, vid_ab     video bus request (held for the burst), fetch address
//   vid_grant           video owns the bus this cycle
//   vid_valid, vid_di   vid_di holds data for the previous granted cycle
//   mem_ab/do/we, mem_di  memory port (mem_di one cycle after its address)
module c64_bus_arbiter #(
  parameter int BA_LEAD        = 3,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_di,
  input  logic        vid_req,
  input  logic [15:0] vid_ab,
  output logic        vid_grant,
  output logic        vid_valid,
  output logic [7:0]  vid_di,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  input  logic [7:0]  mem_di
);

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_LEAD    = 2'd1,
    S_VIDEO   = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] lead_cnt, lead_cnt_nxt;
  logic [7:0] ref_timer;
  logic       ref_pending;
  logic [7:0] ref_row;
  logic       tmr_hit;
  logic       ref_ok;

  assign tmr_hit = (ref_timer == 8'(REFRESH_PERIOD - 1));
  // A refresh may not steal the bus from a CPU write: the CPU cannot halt on one.
  assign ref_ok  = ref_pending && !cpu_we;

  assign cpu_di = mem_di;
  assign vid_di = mem_di;
  assign mem_do = cpu_do;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CPU;
      lead_cnt    <= 3'd0;
      ref_timer   <= 8'd0;
      ref_pending <= 1'b0;
      ref_row     <= 8'd0;
      vid_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lead_cnt  <= lead_cnt_nxt;
      vid_valid <= vid_grant;
      ref_timer <= tmr_hit ? 8'd0 : ref_timer + 8'd1;
      // A new timer expiry on the refresh-exit edge beats the clear.
      if (tmr_hit)
        ref_pending <= 1'b1;
      else if (state == S_REFRESH)
        ref_pending <= 1'b0;
      if (state == S_REFRESH)
        ref_row <= ref_row + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    lead_cnt_nxt = lead_cnt;
    cpu_rdy      = 1'b0;
    vid_grant    = 1'b0;
    mem_ab       = cpu_ab;
    mem_we       = cpu_we;
    case (state)
      S_CPU: begin
        cpu_rdy = 1'b1;
        if (vid_req) begin
          state_nxt    = S_LEAD;
          lead_cnt_nxt = 3'(BA_LEAD - 1);
        end else if (ref_ok) begin
          state_nxt = S_REFRESH;
        end
      end
      S_LEAD: begin
        // CPU is warned but still drives the bus so a write can finish.
        if (vid_req) begin
          if (lead_cnt == 3'd0)
            state_nxt = S_VIDEO;
          else
            lead_cnt_nxt = lead_cnt - 3'd1;
        end else begin
          state_nxt = ref_ok ? S_REFRESH : S_CPU;
        end
      end
      S_VIDEO: begin
        vid_grant = 1'b1;
        mem_ab    = vid_ab;
        mem_we    = 1'b0;
        if (!vid_req)
          state_nxt = ref_pending ? S_REFRESH : S_CPU;
      end
      S_REFRESH: begin
        mem_ab    = {8'hFF, ref_row};
        mem_we    = 1'b0;
        state_nxt = S_CPU;
      end
      default: state_nxt = S_CPU;
    endcase
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - directed and randomized checks of c64_bus_arbiter
module tb_c64_bus_arbiter;

  localparam int BA_LEAD = 3;
  localparam int RP      = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = 16'h0;
  logic [7:0]  cpu_do = 8'h0;
  logic        cpu_we = 1'b0;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic        vid_req = 1'b0;
  logic [15:0] vid_ab = 16'h0;
  logic        vid_grant;
  logic        vid_valid;
  logic [7:0]  vid_di;
  logic [15:0] mem_ab;
  logic [7:0]  mem_do;
  logic        mem_we;
  logic [7:0]  mem_di = 8'h0;

  c64_bus_arbiter #(.BA_LEAD(BA_LEAD), .REFRESH_PERIOD(RP)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy), .cpu_di(cpu_di),
    .vid_req(vid_req), .vid_ab(vid_ab), .vid_grant(vid_grant), .vid_valid(vid_valid), .vid_di(vid_di),
    .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: burst age (0 = no burst, 1..BA_LEAD = warning, beyond = granted),
  // a one-cycle refresh flag and the refresh period counted in plain integers.
  int         age = 0;
  bit         refresh = 0;
  bit         pending = 0;
  bit         prev_grant = 0;
  int         tick = 0;
  logic [7:0] row = 8'h00;
  int         wraps = 0;
  int         n_refresh = 0;

  logic        last_grant, last_rdy, last_we;
  logic [15:0] last_ab;
  logic [7:0]  last_do;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit vr, input bit we, input logic [15:0] cab, input logic [7:0] cdo);
    bit          e_grant, e_rdy, e_we, fire;
    logic [15:0] e_ab;
    @(negedge clk);
    reset   = r;
    vid_req = vr;
    cpu_we  = we;
    cpu_ab  = cab;
    cpu_do  = cdo;
    vid_ab  = 16'($urandom);
    mem_di  = 8'($urandom);
    #1;
    e_grant = (age > BA_LEAD);
    e_rdy   = (age == 0) && !refresh;
    e_ab    = refresh ? {8'hFF, row} : (e_grant ? vid_ab : cab);
    e_we    = (refresh || e_grant) ? 1'b0 : we;
    chk("cpu_rdy", cpu_rdy, e_rdy);
    chk("vid_grant", vid_grant, e_grant);
    chk("vid_valid", vid_valid, prev_grant);
    chk("mem_ab", mem_ab, e_ab);
    chk("mem_we", mem_we, e_we);
    chk("mem_do", mem_do, cdo);
    chk("cpu_di", cpu_di, mem_di);
    chk("vid_di", vid_di, mem_di);
    last_grant = vid_grant;
    last_rdy   = cpu_rdy;
    last_we    = mem_we;
    last_ab    = mem_ab;
    last_do    = mem_do;
    @(posedge clk);
    if (r) begin
      age = 0; refresh = 0; tick = 0; pending = 0; row = 8'h00; prev_grant = 0;
    end else begin
      fire       = (tick == RP - 1);
      tick       = fire ? 0 : tick + 1;
      prev_grant = e_grant;
      if (refresh) begin
        row = row + 8'd1;
        if (row == 8'h00) wraps++;
        n_refresh++;
        refresh = 0;
        pending = fire;
      end else begin
        if (age == 0) begin
          if (vr) age = 1;
          else if (pending && !we) refresh = 1;
        end else if (vr) begin
          age++;
        end else begin
          // leaving the grant takes a pending refresh at once; aborting the warning defers to writes
          if (pending && (age > BA_LEAD || !we)) refresh = 1;
          age = 0;
        end
        pending = pending | fire;
      end
    end
  endtask

  initial begin
    int first, cnt;
    bit vr, we;
    int burst;

    cycle(1, 0, 0, 16'h0000, 8'h00);
    cycle(1, 1, 0, 16'h0000, 8'h00);
    cycle(0, 0, 0, 16'h1234, 8'h00);
    chk("reset_rdy", last_rdy, 1'b1);
    chk("reset_grant", last_grant, 1'b0);

    // 10-cycle video burst; write to D020 in the first warning cycle
    first = -1; cnt = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) cycle(0, 1, 1, 16'hD020, 8'h05);
      else        cycle(0, (k < 10), 0, 16'($urandom), 8'($urandom));
      if (k == 1) begin
        chk("lead_wr_we", last_we, 1'b1);
        chk("lead_wr_ab", last_ab, 16'hD020);
        chk("lead_wr_do", last_do, 8'h05);
        chk("lead_wr_rdy", last_rdy, 1'b0);
      end
      if (last_grant) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (k == 11) chk("burst_rdy_back", last_rdy, 1'b1);
    end
    chk("burst_first_grant", first, BA_LEAD + 1);
    chk("burst_grant_len", cnt, 7);

    // aborted request: two cycles only
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, (k < 2), 0, 16'($urandom), 8'($urandom));
      if (last_grant) cnt++;
      if (k == 3) chk("abort_rdy_back", last_rdy, 1'b1);
    end
    chk("abort_no_grant", cnt, 0);

    // reset in the middle of a granted burst
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 16'($urandom), 8'($urandom));
    chk("mid_video_grant", last_grant, 1'b1);
    cycle(1, 1, 0, 16'($urandom), 8'($urandom));
    cycle(0, 1, 0, 16'($urandom), 8'($urandom));
    chk("post_reset_grant", last_grant, 1'b0);
    chk("post_reset_rdy", last_rdy, 1'b1);
    // first refresh after reset must address row 0
    first = -1;
    for (int k = 0; k < RP + 4; k++) begin
      cycle(0, 0, 0, 16'h0400, 8'($urandom));
      if (first < 0 && last_ab == 16'hFF00 && !last_rdy) first = k;
    end
    chk("post_reset_row0_seen", (first >= 0), 1'b1);

    // long randomized run without reset: covers row wrap and write deferral
    burst = 0;
    for (int k = 0; k < 25000; k++) begin
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 12);
      vr = (burst > 0);
      if (burst > 0) burst--;
      we = ($urandom_range(0, 9) < 3);
      cycle(0, vr, we, 16'($urandom), 8'($urandom));
    end
    chk("row_wrapped", (wraps > 0), 1'b1);

    // randomized run with occasional resets
    burst = 0;
    for (int k = 0; k < 3000; k++) begin
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 10);
      vr = (burst > 0);
      if (burst > 0) burst--;
      we = ($urandom_range(0, 9) < 4);
      cycle(($urandom_range(0, 199) == 0), vr, we, 16'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
